// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths:
// default rates, bit-period arithmetic, frame levels and TX state encoding.
package uart_pkg;

   localparam int CLK_FREQ_DEF = 50_000_000;
   localparam int UART_BPS_DEF = 9600;

   localparam int   DATA_BITS = 8;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // Clock cycles per bit, integer-truncated; callers keep it within 2..65535.
   function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

endpackage

// File: rtl/uart_send_if.sv
// Byte-request handshake and serial output of the UART transmitter.
interface uart_send_if;

   logic       uart_en;
   logic [7:0] uart_din;
   logic       uart_ready;
   logic       uart_txd;
   logic       tx_done;

   modport master (
      output uart_en,
      output uart_din,
      input  uart_ready,
      input  uart_txd,
      input  tx_done
   );

   modport slave (
      input  uart_en,
      input  uart_din,
      output uart_ready,
      output uart_txd,
      output tx_done
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts clock cycles within one bit and flags the last
// cycle of the bit. Kept separate so the receiver can reuse it.
module uart_baud_tick #(
   parameter int BPS_CNT = 5208
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic en,
   input  logic clr,
   output logic bit_end
);

   localparam logic [15:0] LAST_CNT = 16'(BPS_CNT - 1);

   logic [15:0] clk_cnt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         clk_cnt <= '0;
      end else if (clr) begin
         clk_cnt <= '0;
      end else if (en) begin
         clk_cnt <= bit_end ? 16'd0 : clk_cnt + 16'd1;
      end
   end

   assign bit_end = (clk_cnt == LAST_CNT);

endmodule

// File: rtl/uart_send.sv
// 8N1 UART transmitter: latches one byte per accepted request and shifts it
// out LSB first between a start and a stop bit, all outputs from flops.
module uart_send
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = CLK_FREQ_DEF,
   parameter int UART_BPS = UART_BPS_DEF
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   uart_send_if.slave bus
);

   localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);

   tx_state_t  state;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic       txd;
   logic       ready;
   logic       done;
   logic       accept;
   logic       bit_end;
   logic       busy;

   assign accept = bus.uart_en && ready;
   assign busy   = (state != TX_IDLE);

   uart_baud_tick #(
      .BPS_CNT (BPS_CNT)
   ) u_baud_tick (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .en        (busy),
      .clr       (accept),
      .bit_end   (bit_end)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= TX_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         txd     <= IDLE_LVL;
         ready   <= 1'b1;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            TX_IDLE: begin
               // ready is only high here, so a request while busy is simply dropped
               if (accept) begin
                  shreg <= bus.uart_din;
                  state <= TX_START;
                  txd   <= START_LVL;
                  ready <= 1'b0;
               end
            end
            TX_START: begin
               if (bit_end) begin
                  state   <= TX_DATA;
                  bit_cnt <= '0;
                  txd     <= shreg[0];
               end
            end
            TX_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == 3'(DATA_BITS - 1)) begin
                     state <= TX_STOP;
                     txd   <= STOP_LVL;
                  end else begin
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + 3'd1;
                     txd     <= shreg[1];
                  end
               end
            end
            TX_STOP: begin
               if (bit_end) begin
                  state <= TX_IDLE;
                  txd   <= IDLE_LVL;
                  ready <= 1'b1;
                  done  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.uart_txd   = txd;
   assign bus.uart_ready = ready;
   assign bus.tx_done    = done;

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: three instances (10, 2 and 5208 cycles per bit) checked
// against a per-cycle expected-line queue and a mid-bit sampling scoreboard.
module tb_uart_send;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       rst_aux_n;
   logic       en_d    [3];
   logic [7:0] din_d   [3];
   logic       txd_w   [3];
   logic       ready_w [3];
   logic       done_w  [3];

   uart_send_if bus [3] ();

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      assign bus[gi].uart_en  = en_d[gi];
      assign bus[gi].uart_din = din_d[gi];
      assign txd_w[gi]   = bus[gi].uart_txd;
      assign ready_w[gi] = bus[gi].uart_ready;
      assign done_w[gi]  = bus[gi].tx_done;

      uart_send #(
         .CLK_FREQ ((gi == 2) ? 50_000_000 : 1_000_000),
         .UART_BPS ((gi == 0) ? 100_000 : ((gi == 1) ? 500_000 : 9600))
      ) u_dut (
         .sys_clk   (clk),
         .sys_rst_n ((gi == 0) ? rst_n : rst_aux_n),
         .bus       (bus[gi])
      );
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int bps_of(input int idx);
      return (idx == 0) ? 10 : ((idx == 1) ? 2 : 5208);
   endfunction

   // Expected {txd, ready, tx_done} per cycle for instance 0, from frame arithmetic.
   logic [2:0] exp_q [$];

   function automatic void push_frame(input logic [7:0] b, input int bps);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int t = 0; t < 10 * bps; t++) exp_q.push_back({fr[t / bps], 2'b00});
      exp_q.push_back(3'b111);
   endfunction

   function automatic void push_idle(input int n);
      for (int t = 0; t < n; t++) exp_q.push_back(3'b110);
   endfunction

   task automatic start_send(input int idx, input logic [7:0] b);
      en_d[idx]  = 1'b1;
      din_d[idx] = b;
      @(negedge clk);
   endtask

   // Walk instance 0 through the queued expectation, one sample per cycle.
   task automatic play(input string tag, input int drop_at, input logic [7:0] din_after,
                       input bit disturb, output int n_done, output int first_done,
                       output int last_done, output int last_gap);
      int         j;
      int         run;
      logic [2:0] e;
      j = 0; run = 0; n_done = 0; first_done = -1; last_done = -1; last_gap = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val($sformatf("%s@%0d", tag, j), {29'd0, txd_w[0], ready_w[0], done_w[0]}, {29'd0, e});
         if (done_w[0]) begin
            if (n_done == 0) first_done = j;
            last_done = j;
            n_done++;
         end
         if (txd_w[0]) run++;
         else begin
            if (run > 0) last_gap = run;
            run = 0;
         end
         if (j == 0) din_d[0] = din_after;
         if (j == drop_at) en_d[0] = 1'b0;
         if (disturb && j >= 15 && j < 80) begin
            din_d[0] = ~din_d[0];
            en_d[0]  = (j == 30 || j == 55);
         end
         @(negedge clk);
         j++;
      end
      $display("frame %s: %0d cycles, %0d done pulses", tag, j, n_done);
   endtask

   // Scoreboard: sample each bit in its middle and measure the frame length.
   task automatic send_mid(input int idx, input logic [7:0] b);
      int         bps;
      int         j;
      logic [9:0] got;
      bps = bps_of(idx);
      got = '0;
      start_send(idx, b);
      en_d[idx] = 1'b0;
      j = 0;
      for (int k = 0; k < 10; k++) begin
         while (j < k * bps + bps / 2) begin
            @(negedge clk);
            j++;
         end
         got[k] = txd_w[idx];
      end
      while (ready_w[idx] == 1'b0 && j < 20 * bps + 10) begin
         @(negedge clk);
         j++;
      end
      check_val($sformatf("start%0d", idx), {31'd0, got[0]}, 32'd0);
      check_val($sformatf("stop%0d", idx), {31'd0, got[9]}, 32'd1);
      check_val($sformatf("data%0d", idx), {24'd0, got[8:1]}, {24'd0, b});
      check_val($sformatf("len%0d", idx), j, 10 * bps);
      check_val($sformatf("done%0d", idx), {31'd0, done_w[idx]}, 32'd1);
      $display("tx dut%0d bps %0d byte %02h got %02h len %0d", idx, bps, b, got[8:1], j);
      @(negedge clk);
      check_val($sformatf("done_end%0d", idx), {31'd0, done_w[idx]}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n_done, first_done, last_done, last_gap;
      for (int i = 0; i < 3; i++) begin
         en_d[i]  = 1'b0;
         din_d[i] = 8'h00;
      end
      rst_n     = 1'b0;
      rst_aux_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset", {29'd0, txd_w[0], ready_w[0], done_w[0]}, 32'h6);
      rst_n     = 1'b1;
      rst_aux_n = 1'b1;

      fork
         begin
            for (int c = 0; c < 50; c++) begin
               @(negedge clk);
               check_val($sformatf("idle@%0d", c), {29'd0, txd_w[0], ready_w[0], done_w[0]}, 32'h6);
            end

            start_send(0, 8'hA5);
            push_frame(8'hA5, 10);
            push_idle(3);
            play("a5", 0, 8'hA5, 1'b0, n_done, first_done, last_done, last_gap);
            check_val("a5_ndone", n_done, 1);
            check_val("a5_done_at", first_done, 100);

            start_send(0, 8'h00);
            push_frame(8'h00, 10);
            push_frame(8'hFF, 10);
            push_idle(3);
            play("b2b", 101, 8'hFF, 1'b0, n_done, first_done, last_done, last_gap);
            check_val("b2b_ndone", n_done, 2);
            check_val("b2b_spacing", last_done - first_done, 101);
            check_val("b2b_gap", last_gap, 11);

            start_send(0, 8'h3C);
            push_frame(8'h3C, 10);
            push_idle(5);
            play("busy_drop", 0, 8'h99, 1'b1, n_done, first_done, last_done, last_gap);
            check_val("drop_ndone", n_done, 1);

            start_send(0, 8'h0F);
            en_d[0] = 1'b0;
            repeat (54) @(negedge clk);
            check_val("pre_rst_bit4", {31'd0, txd_w[0]}, 32'd0);
            rst_n = 1'b0;
            #1;
            check_val("rst_async", {29'd0, txd_w[0], ready_w[0], done_w[0]}, 32'h6);
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               check_val($sformatf("rst_hold@%0d", c), {29'd0, txd_w[0], ready_w[0], done_w[0]}, 32'h6);
            end
            rst_n = 1'b1;
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               check_val($sformatf("post_rst@%0d", c), {29'd0, txd_w[0], ready_w[0], done_w[0]}, 32'h6);
            end
            start_send(0, 8'h55);
            push_frame(8'h55, 10);
            push_idle(2);
            play("after_rst", 0, 8'h55, 1'b0, n_done, first_done, last_done, last_gap);
            check_val("after_rst_ndone", n_done, 1);

            for (int r = 0; r < 8; r++) send_mid(0, 8'($urandom));
            for (int r = 0; r < 16; r++) send_mid(1, 8'($urandom));
         end
         begin
            @(negedge clk);
            send_mid(2, 8'($urandom));
         end
      join

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_send.md
# uart_send

UART transmit block for the Bluetooth link: serialises one byte per request onto `uart_txd` as an 8N1 frame. The frame is one start bit (0), eight data bits LSB first, and one stop bit (1), at `UART_BPS`. It sits between the command/data logic and the Bluetooth module's RX pin. It is the transmit counterpart of the team's UART receive path and uses the same `CLK_FREQ`/`UART_BPS` parameterisation and bit-period arithmetic.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `UART_BPS`, 9600, baud rate.
- `BPS_CNT` (localparam), `CLK_FREQ/UART_BPS` integer-truncated (5208 at defaults), clock cycles per bit. Legal range is 2..65535.
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `sys_rst_n`  in  1  reset: asynchronous, active-low. Clock is `sys_clk`.
- `uart_en`  in  1  send request, sampled every cycle.
- `uart_din`  in  8  byte to send, sampled only on the accept cycle.
- `uart_ready`  out  1  high when the block can accept a byte.
- `uart_txd`  out  1  serial line, idle high.
- `tx_done`  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- FSM states:
  - IDLE: `txd`=1, `ready`=1.
  - START: `txd`=0.
  - DATA: `txd`=`shreg[0]`, `bit_cnt` 0..7.
  - STOP: `txd`=1.
- Accept occurs on any rising edge where `uart_en`=1 and `uart_ready`=1. On that edge:
  - `uart_din` is latched into the 8-bit shift register `shreg`.
  - State goes to START, `clk_cnt` is set to 0, and `uart_ready` goes to 0.
- Per-bit counter `clk_cnt` is 16 bits. It increments every cycle outside IDLE and wraps to 0 at `BPS_CNT-1`. Each wrap advances the FSM:
  - START goes to DATA with `bit_cnt`=0.
  - DATA shifts `shreg` right and increments `bit_cnt`. After `bit_cnt`=7 it goes to STOP.
  - STOP goes to IDLE. `uart_ready` is set to 1 and `tx_done` pulses to 1 for exactly one cycle.
- `uart_en` while `uart_ready`=0 is ignored. It is not queued, and no error is flagged.
- `uart_din` changes after accept have no effect on the frame in flight.
- `uart_txd` is driven directly from a flop, with no combinational path from inputs.
- Reset (any time, including mid-frame) forces all of the following immediately (asynchronous):
  - State to IDLE.
  - `uart_txd`=1, `uart_ready`=1, `tx_done`=0.
  - `clk_cnt`=0, `bit_cnt`=0, `shreg`=0.
  - A truncated frame is not resumed after reset release.

## Timing
- Reset values: `uart_txd`=1, `uart_ready`=1, `tx_done`=0.
- Accept latency: `uart_txd` falls on the edge that accepts, so it is visible the cycle after `uart_en` is sampled high.
- Each bit, including start and stop, lasts exactly `BPS_CNT` cycles.
- From the accept edge, the frame lasts `10*BPS_CNT` cycles until `uart_ready` rises. `tx_done` is high in that same cycle.
- Data bit k (k=0..7) occupies cycles `(1+k)*BPS_CNT` .. `(2+k)*BPS_CNT-1` after the accept edge.
- Back-to-back sends with `uart_en` held high:
  - The next accept happens on the first edge with `uart_ready`=1.
  - The line therefore stays high for `BPS_CNT+1` cycles between frames, which is legal, and the throughput is one byte per `10*BPS_CNT+1` cycles.
- Simultaneous `tx_done` and a new `uart_en`: the new byte is accepted in that cycle. `tx_done` still pulses for one cycle only.

## Structure
- Shared package/header `uart_pkg`, also used by the receive path, holds:
  - The default `CLK_FREQ` and `UART_BPS`.
  - A `BPS_CNT` calculation function.
  - Frame constants: `DATA_BITS`=8, `START_LVL`=0, `STOP_LVL`=1, `IDLE_LVL`=1.
  - The TX state encoding (2-bit: IDLE/START/DATA/STOP).
- One natural sub-module, `uart_baud_tick`. It holds the 16-bit `clk_cnt`, is enabled when not IDLE, clears on accept, and outputs `bit_end` (high when `clk_cnt==BPS_CNT-1`). It can later be shared with the receiver.
- The FSM, shift register and outputs live in `uart_send`. Expected size is about 150-200 lines total.

## Test plan
Bench parameters are `CLK_FREQ`=1000000 and `UART_BPS`=100000, giving `BPS_CNT`=10.
- Reset release, then 50 idle cycles: `uart_txd`=1, `uart_ready`=1 and `tx_done`=0 throughout.
- Send 0xA5:
  - `uart_txd` reads 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles starting the cycle after accept.
  - `uart_ready` goes low for 100 cycles.
  - `tx_done` is high for exactly one cycle, at cycle 100.
- Hold `uart_en`=1 with 0x00, then 0xFF:
  - Two frames with a high gap of 11 cycles.
  - Second byte sampled when `uart_ready` returns.
  - Two `tx_done` pulses, 101 cycles apart.
- During a frame of 0x3C:
  - Pulse `uart_en` with 0x99 and toggle `uart_din` every cycle.
  - The frame is still exactly 0x3C, the 0x99 request is dropped, and only one `tx_done` occurs.
- Assert `sys_rst_n` low mid data-bit 4 of 0x0F:
  - `uart_txd`=1 and `uart_ready`=1 immediately, with no `tx_done`.
  - After release, sending 0x55 produces a clean full frame.
- Random bytes at `BPS_CNT` in {2, 10, 5208}, scoreboard by sampling `uart_txd` mid-bit: every byte matches and the frame length is `10*BPS_CNT`.
